rrp_otf_convert: RTL and testbench
==================================

# rrp_otf_convert

Radix-R on-the-fly converter that sits at the output of the online (MSDF) multiplier and turns its redundant signed-digit product stream into a conventional two's-complement word. It consumes one digit per accepted beat, most-significant first. It discards the multiplier's online-delay digits and, after WIDTH significant digits, presents the assembled result through a valid/ready handshake. Conversion uses the Q/QM on-the-fly scheme, so no carry-propagating add is needed at the end.

## Interface

- RADIX, 4: digit radix, power of 2 and ≥2; K = log2(RADIX) result bits per digit.
- WIDTH, 8: significant digits per result word.
- DELAY, 3: leading online-delay digits per word, accepted and discarded.
- D (localparam) = $clog2(RADIX)+1: digit width. Digits are two's complement, legal range −(RADIX−1)..RADIX−1.
- W (localparam) = WIDTH*K+1: result width.

Ports:

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_digit  in  D  signed product digit, MSD first.
- in_valid  in  1  in_digit is valid.
- in_ready  out  1  converter accepts in_digit this cycle.
- out_word  out  W  two's-complement result = Σ d_i·RADIX^(WIDTH−i), i = 1..WIDTH.
- out_valid  out  1  out_word is valid.
- out_ready  in  1  downstream accepts out_word.
- err  out  1  sticky: an illegal or nonzero-delay digit was accepted in the current word.

## Operation

- Accept: in_valid && in_ready.
- States and transitions:
  - SKIP: accepts DELAY digits. Any nonzero digit sets err; the value is ignored. After the DELAY-th accept, go to CONV. If DELAY = 0, SKIP is bypassed.
  - CONV: accepts WIDTH digits and updates Q/QM on each accept. After the WIDTH-th accept, go to HOLD.
  - HOLD: out_valid = 1.
    - On out_ready, go to SKIP (or CONV if DELAY = 0).
    - Q is cleared to 0, QM is set to all-ones (−1), and err is cleared.
- in_ready = (state != HOLD) || out_ready. A digit accepted in the same cycle as the out handshake counts as beat 0 of the next word.
  - If that digit is illegal, the new word's err is set, overriding the clear.
- CONV update, with d = digit and all arithmetic mod 2^W:
  - Q' = (d ≥ 0) ? (Q<<K)|d : (QM<<K)|(RADIX+d).
  - QM' = (d > 0) ? (Q<<K)|(d−1) : (QM<<K)|(RADIX−1+d).
- Illegal digit: d = −RADIX, the only out-of-range D-bit code, e.g. 3'b100 for RADIX 4.
  - It sets err and is treated as 0.
  - It is consumed normally, so the word framing is unchanged.
- out_word = Q while in HOLD; its value is stable and held until the handshake.
- Beat counter runs 0..max(DELAY,WIDTH)−1 and wraps to 0 on each state change.
- in_digit is ignored when in_valid = 0, and the counter does not advance.

## Timing

- Reset values (rst_n = 0 at a clock edge):
  - state = SKIP (CONV if DELAY = 0), counter 0, Q = 0, QM = all-ones.
  - out_valid = 0, out_word = 0, err = 0.
  - in_ready = 1 in the cycle after reset.
- Reset mid-word discards the partial word with no out_valid. Reset in HOLD drops out_valid on the next cycle.
- Latency: out_valid rises on the cycle after the last CONV digit is accepted.
- Throughput: one digit per cycle sustained. With out_ready tied high, words are back-to-back with no bubble, so each word takes DELAY+WIDTH cycles.
- out_word and out_valid are registered; there is no combinational in→out path.
- in_ready depends combinationally on out_ready only.
- err is valid alongside out_valid and is held through HOLD.

## Test plan

Parameters RADIX = 4, WIDTH = 4, DELAY = 0 (W = 9) unless stated.

- Digits 1, −2, 3, −1, then out_ready = 1 → out_word = 9'h02B (43), err = 0, out_valid one cycle after the 4th accept.
- Digits −3, −3, −3, −3 → 9'h101 (−255). Digits 3, 3, 3, 3 → 9'h0FF (255). Digits 0, 0, 0, −1 → 9'h1FF (−1).
- Backpressure: out_ready = 0 for 5 cycles in HOLD → in_ready = 0 and out_word stable. Raising out_ready with in_valid = 1 and digit 2 in the same cycle accepts the digit as the first digit of the next word.
- Digit 3'b100 at beat 2 of 1, 1, −4, 1 → err = 1, out_word = 9'h051 (1,1,0,1 = 81). err clears after the handshake.
- DELAY = 3: stream 0, 0, 0, 1, −2, 3, −1 → 9'h02B. Stream 0, 1, 0, … → err = 1.
- rst_n low after 2 CONV digits → no out_valid. The next 4 digits 0, 0, 0, 1 → 9'h001.

Source files
------------

// File: rtl/rrp_otf_convert_if.sv
// Digit-in / word-out handshake bundle for the on-the-fly converter.
// slave = converter side, master = producer/consumer side.
interface rrp_otf_convert_if #(
  parameter int RADIX = 4,
  parameter int WIDTH = 8
);
  localparam int K = $clog2(RADIX);
  localparam int D = K + 1;
  localparam int W = WIDTH * K + 1;

  logic signed [D-1:0] in_digit;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        out_word;
  logic                out_valid;
  logic                out_ready;
  logic                err;

  modport slave (
    input  in_digit, in_valid, out_ready,
    output in_ready, out_word, out_valid, err
  );

  modport master (
    output in_digit, in_valid, out_ready,
    input  in_ready, out_word, out_valid, err
  );
endinterface

// File: rtl/rrp_otf_convert.sv
// Q/QM on-the-fly conversion of an MSD-first signed-digit stream into a two's-complement word.
// Result registered one cycle after the last digit; in_ready drops only while a word is held and out_ready is low.
module rrp_otf_convert #(
  parameter int RADIX = 4,
  parameter int WIDTH = 8,
  parameter int DELAY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  rrp_otf_convert_if.slave bus
);
  localparam int K    = $clog2(RADIX);
  localparam int D    = K + 1;
  localparam int W    = WIDTH * K + 1;
  localparam int MAXC = (DELAY > WIDTH) ? DELAY : WIDTH;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] LAST_SKIP = CW'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic [CW-1:0] LAST_CONV = CW'(WIDTH - 1);

  typedef enum logic [1:0] {SKIP, CONV, HOLD} state_t;
  localparam state_t FIRST = (DELAY == 0) ? CONV : SKIP;

  state_t              state, eff_state, nxt_state;
  logic [CW-1:0]       cnt, eff_cnt, nxt_cnt;
  logic [W-1:0]        q, qm, eff_q, eff_qm, nxt_q, nxt_qm;
  logic [W-1:0]        word;
  logic                err_r, eff_err, nxt_err;
  logic                out_valid_r;
  logic signed [D-1:0] d_raw, d;
  logic [K-1:0]        lo, lo_m1;
  logic                illegal, accept, d_pos;

  assign d_raw   = bus.in_digit;
  assign illegal = (d_raw == {1'b1, {K{1'b0}}});
  assign d       = illegal ? '0 : d_raw;
  // Low K bits of d and d-1 equal (RADIX+d) and (RADIX-1+d) modulo RADIX.
  assign lo      = d[K-1:0];
  assign lo_m1   = lo - K'(1);
  assign d_pos   = !d[D-1] && (d != '0);

  assign bus.in_ready  = (state != HOLD) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_word  = word;
  assign bus.out_valid = out_valid_r;
  assign bus.err       = err_r;

  always_comb begin
    // A handshake in HOLD starts the next word in the same cycle, so its first digit sees cleared state.
    eff_state = state;
    eff_cnt   = cnt;
    eff_q     = q;
    eff_qm    = qm;
    eff_err   = err_r;
    if (state == HOLD && bus.out_ready) begin
      eff_state = FIRST;
      eff_cnt   = '0;
      eff_q     = '0;
      eff_qm    = '1;
      eff_err   = 1'b0;
    end

    nxt_state = eff_state;
    nxt_cnt   = eff_cnt;
    nxt_q     = eff_q;
    nxt_qm    = eff_qm;
    nxt_err   = eff_err;
    if (accept) begin
      case (eff_state)
        SKIP: begin
          nxt_err = eff_err | (d_raw != '0);
          nxt_cnt = eff_cnt + CW'(1);
          if (eff_cnt == LAST_SKIP) begin
            nxt_state = CONV;
            nxt_cnt   = '0;
          end
        end
        CONV: begin
          nxt_err = eff_err | illegal;
          nxt_q   = !d[D-1] ? {eff_q[W-K-1:0], lo} : {eff_qm[W-K-1:0], lo};
          nxt_qm  = d_pos ? {eff_q[W-K-1:0], lo_m1} : {eff_qm[W-K-1:0], lo_m1};
          nxt_cnt = eff_cnt + CW'(1);
          if (eff_cnt == LAST_CONV) begin
            nxt_state = HOLD;
            nxt_cnt   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FIRST;
      cnt         <= '0;
      q           <= '0;
      qm          <= '1;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      word        <= '0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      q           <= nxt_q;
      qm          <= nxt_qm;
      err_r       <= nxt_err;
      out_valid_r <= (nxt_state == HOLD);
      if (nxt_state == HOLD) begin
        word <= nxt_q;
      end
    end
  end
endmodule

// File: tb/tb_rrp_otf_convert.sv
// Scoreboard bench: two converters (online delay 0 and 3) against an arithmetic digit-sum model.
`timescale 1ns/1ps
module tb_rrp_otf_convert;
  localparam int RADIX = 4;
  localparam int WIDTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];
  int   bc[2];
  int   acc[2];
  bit   er[2];

  always #5 clk = ~clk;

  rrp_otf_convert_if #(.RADIX(RADIX), .WIDTH(WIDTH)) bus_a ();
  rrp_otf_convert_if #(.RADIX(RADIX), .WIDTH(WIDTH)) bus_b ();

  rrp_otf_convert #(.RADIX(RADIX), .WIDTH(WIDTH), .DELAY(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  rrp_otf_convert #(.RADIX(RADIX), .WIDTH(WIDTH), .DELAY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word value is the plain weighted digit sum, reduced to 9 bits; illegal digit counts as 0.
  task automatic model_accept(input int w, input int d);
    int dl;
    logic [9:0] e;
    dl = (w == 0) ? 0 : 3;
    if (bc[w] < dl) begin
      if (d != 0) er[w] = 1'b1;
    end else begin
      if (d == -RADIX) begin
        er[w] = 1'b1;
        d = 0;
      end
      acc[w] = acc[w] * RADIX + d;
    end
    bc[w]++;
    if (bc[w] == dl + WIDTH) begin
      e = {er[w], acc[w][8:0]};
      if (w == 0) q_a.push_back(e);
      else        q_b.push_back(e);
      bc[w]  = 0;
      acc[w] = 0;
      er[w]  = 1'b0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      bc[i]  = 0;
      acc[i] = 0;
      er[i]  = 1'b0;
    end
  endtask

  // One cycle: drive at posedge+1, sample handshake at negedge, return at next posedge+1.
  task automatic cyc(input int w, input bit v, input int d, input bit ordy, output bit got);
    if (w == 0) begin
      bus_a.in_valid = v; bus_a.in_digit = 3'(d); bus_a.out_ready = ordy;
    end else begin
      bus_b.in_valid = v; bus_b.in_digit = 3'(d); bus_b.out_ready = ordy;
    end
    @(negedge clk);
    got = v && ((w == 0) ? bus_a.in_ready : bus_b.in_ready) && rst_n;
    if (got) model_accept(w, d);
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input int w, input int d0, input int d1, input int d2, input int d3,
                       input bit ordy);
    int ds[4];
    bit got;
    ds = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      int tries = 0;
      got = 1'b0;
      while (!got && tries < 20) begin
        cyc(w, 1'b1, ds[i], ordy, got);
        tries++;
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL send_timeout: digit %0d got accepted=0 required=1 within 20 cycles", i);
      end
    end
    if (w == 0) bus_a.in_valid = 1'b0;
    else        bus_b.in_valid = 1'b0;
  endtask

  task automatic drain(input int w);
    bit got;
    repeat (6) cyc(w, 1'b0, 0, 1'b1, got);
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected: got word %0h with no word expected", bus_a.out_word);
      end else begin
        e = q_a.pop_front();
        check("a_word", 32'(bus_a.out_word), 32'(e[8:0]));
        check("a_err", 32'(bus_a.err), 32'(e[9]));
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected: got word %0h with no word expected", bus_b.out_word);
      end else begin
        e = q_b.pop_front();
        check("b_word", 32'(bus_b.out_word), 32'(e[8:0]));
        check("b_err", 32'(bus_b.err), 32'(e[9]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got;
    int d;
    bus_a.in_valid = 1'b0; bus_a.in_digit = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_digit = '0; bus_b.out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out_valid", 32'(bus_a.out_valid), 0);
    check("rst_a_out_word", 32'(bus_a.out_word), 0);
    check("rst_a_err", 32'(bus_a.err), 0);
    check("rst_a_in_ready", 32'(bus_a.in_ready), 1);
    check("rst_b_in_ready", 32'(bus_b.in_ready), 1);
    rst_n = 1'b1;

    // Latency and backpressure.
    send4(0, 1, -2, 3, -1, 1'b0);
    check("a_latency_valid", 32'(bus_a.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1'b1, 2, 1'b0, got);
      check("a_bp_in_ready", 32'(bus_a.in_ready), 0);
      check("a_bp_word_stable", 32'(bus_a.out_word), 32'h02B);
      check("a_bp_valid", 32'(bus_a.out_valid), 1);
    end
    cyc(0, 1'b1, 2, 1'b1, got);
    check("a_hs_digit_accepted", 32'(got), 1);
    cyc(0, 1'b1, 0, 1'b1, got);
    cyc(0, 1'b1, 0, 1'b1, got);
    cyc(0, 1'b1, 1, 1'b1, got);

    send4(0, -3, -3, -3, -3, 1'b1);
    send4(0, 3, 3, 3, 3, 1'b1);
    send4(0, 0, 0, 0, -1, 1'b1);
    send4(0, 1, 1, -4, 1, 1'b1);
    check("a_err_set", 32'(bus_a.err), 1);
    send4(0, 0, 0, 0, 0, 1'b1);
    drain(0);

    for (int i = 0; i < 600; i++) begin
      d = int'($urandom_range(7)) - 4;
      cyc(0, $urandom_range(3) != 0, d, $urandom_range(1) == 1, got);
    end
    drain(0);
    check("a_drained", 32'(q_a.size()), 0);

    // Online-delay variant.
    for (int i = 0; i < 3; i++) cyc(1, 1'b1, 0, 1'b1, got);
    send4(1, 1, -2, 3, -1, 1'b1);
    check("b_latency_valid", 32'(bus_b.out_valid), 1);
    cyc(1, 1'b1, 0, 1'b1, got);
    cyc(1, 1'b1, 1, 1'b1, got);
    cyc(1, 1'b1, 0, 1'b1, got);
    send4(1, 0, 0, 0, 0, 1'b1);
    check("b_delay_err", 32'(bus_b.err), 1);
    drain(1);

    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(1) == 1) ? 0 : int'($urandom_range(7)) - 4;
      cyc(1, $urandom_range(3) != 0, d, $urandom_range(1) == 1, got);
    end
    drain(1);
    check("b_drained", 32'(q_b.size()), 0);

    // Reset discards partial words.
    rst_n = 1'b0;
    cyc(0, 1'b0, 0, 1'b1, got);
    rst_n = 1'b1;
    model_clear();
    cyc(0, 1'b1, 1, 1'b1, got);
    cyc(0, 1'b1, 2, 1'b1, got);
    rst_n = 1'b0;
    cyc(0, 1'b0, 0, 1'b1, got);
    rst_n = 1'b1;
    model_clear();
    check("mid_rst_word", 32'(bus_a.out_word), 0);
    check("mid_rst_in_ready", 32'(bus_a.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 0, 1'b1, got);
      check("mid_rst_no_valid", 32'(bus_a.out_valid), 0);
    end
    send4(0, 0, 0, 0, 1, 1'b1);
    check("post_rst_word", 32'(bus_a.out_word), 32'h001);
    drain(0);
    check("a_final_drained", 32'(q_a.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
